alien_plot_arbiter: RTL and testbench
=====================================

ALIEN_PLOT_ARBITER -- requirements
Module: alien_plot_arbiter

Interface
REQ-001 Parameter N_REQ, 8, number of alien sprite requesters.
REQ-002 Parameter SPR_W, 4, sprite width in pixels.
REQ-003 Parameter SPR_H, 4, sprite height in pixels.
REQ-004 Reset resetn, synchronous, active-low; clock clk.
REQ-005 clk  input  1  system clock.
REQ-006 resetn  input  1  synchronous active-low reset.
REQ-007 req  input  N_REQ  per-alien redraw request, held high until matching ack.
REQ-008 req_x  input  8*N_REQ  packed new sprite top-left x, alien i at bits [8i+7:8i].
REQ-009 req_y  input  7*N_REQ  packed new sprite top-left y, alien i at bits [7i+6:7i].
REQ-010 req_colour  input  3*N_REQ  packed sprite colour.
REQ-011 ack  output  N_REQ  one-cycle pulse on the served alien's bit when its redraw completes.
REQ-012 vga_x  output  8  pixel x to the VGA adapter.
REQ-013 vga_y  output  7  pixel y to the VGA adapter.
REQ-014 vga_colour  output  3  pixel colour.
REQ-015 vga_plot  output  1  pixel write enable.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The block SHALL serialise all requesters onto the single VGA plot port; one alien is served at a time.
REQ-018 States: IDLE, ERASE, DRAW, ACK; encoding in the shared package.
REQ-019 In IDLE with req != 0, the block SHALL pick a winner round-robin, starting from index (last_grant+1) mod N_REQ, and latch its x, y and colour in that cycle.
REQ-020 last_grant SHALL update to the winner index on every grant; it resets to N_REQ-1, so index 0 wins first.
REQ-021 Per alien, the block SHALL hold old_x, old_y, old_colour and a valid bit for the last drawn sprite.
REQ-022 Transitions from IDLE on grant: valid set and x/y/colour equal to stored values -> ACK; valid set and values differ -> ERASE; valid clear -> DRAW.
REQ-023 ERASE SHALL last exactly SPR_W*SPR_H cycles and plot colour 3'b000 at (old_x+px, old_y+py), then go to DRAW.
REQ-024 DRAW SHALL last exactly SPR_W*SPR_H cycles and plot the latched colour at (new_x+px, new_y+py), then go to ACK.
REQ-025 Pixel order: px = cnt mod SPR_W, py = cnt / SPR_W, with cnt running 0..SPR_W*SPR_H-1 and cleared on every state entry.
REQ-026 ACK SHALL last one cycle, pulse ack[winner], write the latched values into old_* and set valid[winner]; next state IDLE.
REQ-027 Latency from the grant cycle t: with erase, ack at t+33; first draw, ack at t+17; unchanged sprite, ack at t+1 (defaults SPR_W=SPR_H=4).
REQ-028 Coordinates SHALL be summed at 9 bits (x) and 8 bits (y); when x>159 or y>119, vga_plot SHALL be 0 for that cycle, and the cycle is still consumed.
REQ-029 vga_plot SHALL be 0 in IDLE and ACK; vga_x, vga_y and vga_colour are don't-care whenever vga_plot=0.
REQ-030 Deassertion of req[winner] mid-operation SHALL NOT abort; the operation completes and ack still pulses.
REQ-031 Requests asserted during an operation SHALL wait; they are arbitrated in the first IDLE cycle after ACK.
REQ-032 A requester still high in the cycle after its ack SHALL be treated as a new request.

Reset
REQ-033 On resetn=0 at a clock edge: state=IDLE, cnt=0, last_grant=N_REQ-1, all valid=0, ack=0, vga_plot=0, busy=0.
REQ-034 Reset mid-operation SHALL abandon the operation with no ack; the partly drawn sprite is not erased.
REQ-035 old_x, old_y and old_colour need no reset; valid=0 masks them.

Structure
REQ-036 Package alien_gfx_pkg SHALL hold SCREEN_W=160, SCREEN_H=120, COLOUR_W=3, BG_COLOUR=3'b000 and the state encoding.
REQ-037 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, last_grant; outputs winner index and found flag), combinational.

Verification
REQ-038 After reset, req=8'h01 with x=10, y=20, colour=3'b100 -> 16 plots (10..13, 20..23) in colour 3'b100, no erase, ack[0] at t+17.
REQ-039 Then req[0] with x=11 -> 16 erase plots at x 10..13 in colour 0, then 16 draws at x 11..14, ack[0] at t+33.
REQ-040 req[0] again with identical x/y/colour -> no vga_plot, ack[0] at t+1.
REQ-041 req=8'hFF held from reset -> grants in order 0,1,...,7,0; each ack only on its own bit.
REQ-042 First draw at x=158, y=118 -> only the 4 pixels with x≤159 and y≤119 plotted; ack still at t+17.
REQ-043 resetn=0 during DRAW cycle 5 -> next cycle state IDLE, busy=0, no ack; that alien's next request draws with no erase.

Source files
------------

// File: rtl/alien_gfx_pkg.sv
// Shared screen geometry, colour constants and plot-arbiter state encoding.
package alien_gfx_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] BG_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    ACK   = 2'd3
  } state_t;

  function automatic logic on_screen(input logic [8:0] x, input logic [7:0] y);
    return (x < 9'(SCREEN_W)) && (y < 8'(SCREEN_H));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after last_grant+1, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    w_sum  = '0;
    w_idx  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_sum = {1'b0, last_grant} + (IDX_W+1)'(k);
      w_idx = (w_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_sum - (IDX_W+1)'(N)) : IDX_W'(w_sum);
      if (!found && req[w_idx]) begin
        found  = 1'b1;
        winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/alien_plot_arbiter.sv
// Serialises alien sprite redraw requests onto one VGA plot port: erase old sprite,
// draw new one, then acknowledge the served requester.
module alien_plot_arbiter
  import alien_gfx_pkg::*;
#(
  parameter int unsigned N_REQ = 8,
  parameter int unsigned SPR_W = 4,
  parameter int unsigned SPR_H = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_REQ-1:0]      req,
  input  logic [8*N_REQ-1:0]    req_x,
  input  logic [7*N_REQ-1:0]    req_y,
  input  logic [3*N_REQ-1:0]    req_colour,
  output logic [N_REQ-1:0]      ack,
  output logic [7:0]            vga_x,
  output logic [6:0]            vga_y,
  output logic [COLOUR_W-1:0]   vga_colour,
  output logic                  vga_plot,
  output logic                  busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NPIX  = SPR_W * SPR_H;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NPIX - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_last;
  logic [IDX_W-1:0]     r_win;
  logic [N_REQ-1:0]     r_valid;
  logic [N_REQ-1:0]     r_ack;
  logic                 r_plot;
  logic                 r_busy;
  logic [7:0]           r_vga_x;
  logic [6:0]           r_vga_y;
  logic [COLOUR_W-1:0]  r_vga_colour;
  logic [7:0]           r_new_x;
  logic [6:0]           r_new_y;
  logic [COLOUR_W-1:0]  r_colour;
  logic [7:0]           r_old_x      [N_REQ];
  logic [6:0]           r_old_y      [N_REQ];
  logic [COLOUR_W-1:0]  r_old_colour [N_REQ];

  logic [7:0]           w_rx [N_REQ];
  logic [6:0]           w_ry [N_REQ];
  logic [COLOUR_W-1:0]  w_rc [N_REQ];
  logic [IDX_W-1:0]     w_winner;
  logic                 w_found;
  logic                 w_same;
  logic                 w_load;
  logic [7:0]           w_bx;
  logic [6:0]           w_by;
  logic [COLOUR_W-1:0]  w_bc;
  logic [CNT_W-1:0]     w_pc;
  logic [8:0]           w_px9;
  logic [7:0]           w_py8;
  logic                 w_plot;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_rx[i] = req_x[8*i +: 8];
      w_ry[i] = req_y[7*i +: 7];
      w_rc[i] = req_colour[3*i +: 3];
    end
  end

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req        (req),
    .last_grant (r_last),
    .winner     (w_winner),
    .found      (w_found)
  );

  assign w_same = r_valid[w_winner]
               && (w_rx[w_winner] == r_old_x[w_winner])
               && (w_ry[w_winner] == r_old_y[w_winner])
               && (w_rc[w_winner] == r_old_colour[w_winner]);

  // Pixel for the *next* cycle, so the VGA outputs can be registered in step with the FSM.
  always_comb begin
    w_load = 1'b0;
    w_bx   = r_new_x;
    w_by   = r_new_y;
    w_bc   = r_colour;
    w_pc   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_found && !w_same) begin
          w_load = 1'b1;
          if (r_valid[w_winner]) begin
            w_bx = r_old_x[w_winner];
            w_by = r_old_y[w_winner];
            w_bc = BG_COLOUR;
          end else begin
            w_bx = w_rx[w_winner];
            w_by = w_ry[w_winner];
            w_bc = w_rc[w_winner];
          end
        end
      end
      ERASE: begin
        w_load = 1'b1;
        if (r_cnt != LAST_CNT) begin
          w_bx = r_old_x[r_win];
          w_by = r_old_y[r_win];
          w_bc = BG_COLOUR;
          w_pc = r_cnt + 1'b1;
        end
      end
      DRAW: begin
        if (r_cnt != LAST_CNT) begin
          w_load = 1'b1;
          w_pc   = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
    w_px9  = {1'b0, w_bx} + 9'(w_pc % CNT_W'(SPR_W));
    w_py8  = {1'b0, w_by} + 8'(w_pc / CNT_W'(SPR_W));
    w_plot = w_load && on_screen(w_px9, w_py8);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= IDX_W'(N_REQ - 1);
      r_valid <= '0;
      r_ack   <= '0;
      r_plot  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_plot <= w_plot;
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_last <= w_winner;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (!r_valid[w_winner]) begin
              r_state <= DRAW;
            end else if (w_same) begin
              r_state <= ACK;
              r_ack   <= N_REQ'(1) << w_winner;
            end else begin
              r_state <= ERASE;
            end
          end
        end
        ERASE: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_state <= DRAW;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DRAW: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= '0;
            r_state <= ACK;
            r_ack   <= N_REQ'(1) << r_win;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ACK: begin
          r_valid[r_win] <= 1'b1;
          r_state        <= IDLE;
          r_busy         <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_vga_x      <= w_px9[7:0];
    r_vga_y      <= w_py8[6:0];
    r_vga_colour <= w_bc;
    if (r_state == IDLE && w_found) begin
      r_win    <= w_winner;
      r_new_x  <= w_rx[w_winner];
      r_new_y  <= w_ry[w_winner];
      r_colour <= w_rc[w_winner];
    end
    if (r_state == ACK) begin
      r_old_x[r_win]      <= r_new_x;
      r_old_y[r_win]      <= r_new_y;
      r_old_colour[r_win] <= r_colour;
    end
  end

  assign ack        = r_ack;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_plot;
  assign busy       = r_busy;

endmodule

// File: tb/tb_alien_plot_arbiter.sv
// Directed bench for alien_plot_arbiter: table of redraw transactions plus reset and round-robin sequences.
module tb_alien_plot_arbiter;

  localparam int N  = 8;
  localparam int SW = 4;
  localparam int SH = 4;

  typedef struct {
    int unsigned idx;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  col;
    bit          erase;
    logic [7:0]  ox;
    logic [6:0]  oy;
    int unsigned lat;
    bit          drop;
  } vec_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  req;
  logic [8*N-1:0] req_x;
  logic [7*N-1:0] req_y;
  logic [3*N-1:0] req_colour;
  logic [N-1:0]  ack;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [2:0]    vga_colour;
  logic          vga_plot;
  logic          busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  alien_plot_arbiter #(.N_REQ(N), .SPR_W(SW), .SPR_H(SH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .ack        (ack),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_alien(input int unsigned i, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c);
    req_x[8*i +: 8]      = x;
    req_y[7*i +: 7]      = y;
    req_colour[3*i +: 3] = c;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [17:0] q[$];
    logic [17:0] e;
    int unsigned lat;
    bit busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    if (v.erase)
      for (int c = 0; c < SW*SH; c++) begin
        int ex = int'(v.ox) + c % SW;
        int ey = int'(v.oy) + c / SW;
        if (ex < 160 && ey < 120) q.push_back({8'(ex), 7'(ey), 3'b000});
      end
    if (v.lat != 1)
      for (int c = 0; c < SW*SH; c++) begin
        int ex = int'(v.x) + c % SW;
        int ey = int'(v.y) + c / SW;
        if (ex < 160 && ey < 120) q.push_back({8'(ex), 7'(ey), v.col});
      end
    set_alien(v.idx, v.x, v.y, v.col);
    req[v.idx] = 1'b1;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (v.drop && k == 3) req[v.idx] = 1'b0;
      if (vga_plot === 1'b1) begin
        e = (q.size() != 0) ? q.pop_front() : 18'h3FFFF;
        check({tag, " plot"}, 32'({vga_x, vga_y, vga_colour}), 32'(e));
      end
      if (ack !== '0) begin
        lat = k;
        check({tag, " ack_bit"}, 32'(ack), 32'(1) << v.idx);
      end
    end
    check({tag, " latency"}, lat, v.lat);
    check({tag, " busy_during_op"}, 32'(busy_ok), 32'd1);
    check({tag, " missing_plots"}, q.size(), 32'd0);
    req[v.idx] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  vec_t tv[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned got;
    tv[0] = '{0, 8'd10,  7'd20,  3'd4, 1'b0, 8'd0,   7'd0,   17, 1'b0};
    tv[1] = '{0, 8'd11,  7'd20,  3'd4, 1'b1, 8'd10,  7'd20,  33, 1'b0};
    tv[2] = '{0, 8'd11,  7'd20,  3'd4, 1'b0, 8'd0,   7'd0,   1,  1'b0};
    tv[3] = '{1, 8'd158, 7'd118, 3'd2, 1'b0, 8'd0,   7'd0,   17, 1'b0};
    tv[4] = '{1, 8'd100, 7'd50,  3'd2, 1'b1, 8'd158, 7'd118, 33, 1'b0};
    tv[5] = '{0, 8'd11,  7'd20,  3'd5, 1'b1, 8'd11,  7'd20,  33, 1'b1};
    tv[6] = '{2, 8'd0,   7'd0,   3'd7, 1'b0, 8'd0,   7'd0,   17, 1'b0};
    tv[7] = '{2, 8'd0,   7'd0,   3'd7, 1'b0, 8'd0,   7'd0,   1,  1'b0};

    req = '0; req_x = '0; req_y = '0; req_colour = '0;
    do_reset();
    check("reset ack", 32'(ack), 32'd0);
    check("reset plot", 32'(vga_plot), 32'd0);
    check("reset busy", 32'(busy), 32'd0);

    for (int t = 0; t < 8; t++) run_txn(tv[t], $sformatf("vec%0d", t));

    // Reset in the middle of a first draw: no ack, and the sprite is not considered drawn.
    set_alien(3, 8'd30, 7'd30, 3'd3);
    req[3] = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("mid busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    req[3] = 1'b0;
    @(posedge clk);
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ack", 32'(ack), 32'd0);
    check("midrst plot", 32'(vga_plot), 32'd0);
    resetn = 1'b1;
    run_txn('{3, 8'd30, 7'd30, 3'd3, 1'b0, 8'd0, 7'd0, 17, 1'b0}, "after_rst a3");
    run_txn('{0, 8'd11, 7'd20, 3'd5, 1'b0, 8'd0, 7'd0, 17, 1'b0}, "after_rst a0");

    // All requesters held from reset: grants rotate 0..7 then back to 0.
    resetn = 1'b0;
    req = '1;
    for (int i = 0; i < N; i++) set_alien(i, 8'(i*16), 7'(i), 3'd1);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int n = 0; n <= N; n++) begin
      got = 0;
      for (int k = 0; k < 60 && got == 0; k++) begin
        @(posedge clk);
        #1;
        if (ack !== '0) begin
          got = 1;
          check($sformatf("rr grant%0d", n), 32'(ack), 32'(1) << (n % N));
        end
      end
      if (got == 0) check($sformatf("rr timeout%0d", n), 32'd0, 32'd1);
    end
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rr end busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
